// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: round-robin arbiter sharing one single-port memory between
// NUM_REQ requesters. It runs one access at a time (IDLE -> ISSUE -> [WAIT -> RESP])
// and returns read data to the requester that issued the read.
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rd_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy,
    output logic                      mem_enable,
    output logic                      mem_rd_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic [DATA_W-1:0]         mem_rd_data
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [ID_W-1:0]     id_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                mem_enable_q;
    logic                mem_rd_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wr_data_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     cand;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // Requester index k positions after base, wrapping at NUM_REQ.
    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin search: first valid requester after the last grant, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = next_id(last_grant_q, k);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Ready is offered only in IDLE, and forced low while reset is asserted.
    assign req_ready = (rst && (state_q == IDLE) && win_found) ? (NUM_REQ'(1) << win_id) : '0;
    assign busy      = (state_q != IDLE);

    assign mem_enable  = mem_enable_q;
    assign mem_rd_wr   = mem_rd_wr_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

    // Transaction sequencer with registered memory strobes and response pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= LAST_INIT;
            id_q          <= '0;
            wait_cnt_q    <= '0;
            mem_enable_q  <= 1'b0;
            mem_rd_wr_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
        end else begin
            mem_enable_q <= 1'b0;
            mem_rd_wr_q  <= 1'b0;
            rsp_valid_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        last_grant_q  <= win_id;
                        id_q          <= win_id;
                        mem_enable_q  <= 1'b1;
                        mem_rd_wr_q   <= req_rd_wr[win_id];
                        mem_addr_q    <= addr_arr[win_id];
                        mem_wr_data_q <= wdata_arr[win_id];
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= mem_rd_wr_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt_q == CNT_LAST) begin
                        rsp_data_q  <= mem_rd_data;
                        rsp_valid_q <= NUM_REQ'(1) << id_q;
                        state_q     <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: random and directed stimulus against a transaction-timeline
// model of the arbiter, plus literal expectations for the named scenarios.
module tb_mem_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [3:0]  req_rd_wr = 4'b0;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        mem_enable;
    logic        mem_rd_wr;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;

    logic [2:0]  a_arr [4];
    logic [7:0]  d_arr [4];

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign req_addr[g*3 +: 3]  = a_arr[g];
        assign req_wdata[g*8 +: 8] = d_arr[g];
    end

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rd_wr(req_rd_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .mem_enable(mem_enable), .mem_rd_wr(mem_rd_wr),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Memory behind the arbiter: data appears the cycle after a read strobe.
    logic [7:0] env_mem [8];
    always @(posedge clk) begin
        if (mem_enable) begin
            if (mem_rd_wr) env_mem[mem_addr] = mem_wr_data;
            else           mem_rd_data <= env_mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    int         cyc = 0;
    int         idle_from = 0;
    int         issue_cyc = -1;
    int         rsp_cyc = -1;
    logic [1:0] m_last = 2'd3;
    logic [1:0] t_id = 2'd0;
    logic       t_rw = 1'b0;
    logic [2:0] e_addr = 3'd0;
    logic [7:0] e_wd = 8'd0;
    logic [7:0] e_rspd = 8'd0;
    logic [7:0] rsp_pend = 8'd0;
    logic [7:0] mmem [8];

    function automatic bit pick(input logic [3:0] v, input logic [1:0] last, output logic [1:0] id);
        logic [1:0] ix;
        id = 2'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            ix = 2'((int'(last) + k) % NUM_REQ);
            if (v[ix]) begin
                id = ix;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_reset();
        idle_from = 0;
        issue_cyc = -1;
        rsp_cyc   = -1;
        m_last    = 2'd3;
        e_addr    = 3'd0;
        e_wd      = 8'd0;
        e_rspd    = 8'd0;
    endfunction

    // Accepts a transaction whenever the arbiter is free and schedules its events.
    always @(posedge clk) begin
        logic [1:0] w;
        if (rst && cyc >= idle_from && pick(req_valid, m_last, w)) begin
            m_last    = w;
            t_id      = w;
            t_rw      = req_rd_wr[w];
            e_addr    = a_arr[w];
            e_wd      = d_arr[w];
            issue_cyc = cyc + 1;
            if (t_rw) begin
                mmem[e_addr] = e_wd;
                idle_from    = cyc + 2;
            end else begin
                rsp_pend  = mmem[e_addr];
                rsp_cyc   = cyc + 2 + RD_LAT;
                idle_from = cyc + 3 + RD_LAT;
            end
        end
        cyc++;
        if (cyc == rsp_cyc) e_rspd = rsp_pend;
    end

    int         grant_q[$];
    int         rsp_id_q[$];
    logic [7:0] rsp_dat_q[$];

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [1:0] w;
        logic [3:0] er;
        logic       een;
        er  = (rst && cyc >= idle_from && pick(req_valid, m_last, w)) ? (4'b1 << w) : 4'b0;
        een = (cyc == issue_cyc);
        chk("req_ready",   32'(req_ready),   32'(er));
        chk("busy",        32'(busy),        32'(rst && cyc < idle_from));
        chk("mem_enable",  32'(mem_enable),  32'(een));
        chk("mem_rd_wr",   32'(mem_rd_wr),   32'(een ? t_rw : 1'b0));
        chk("mem_addr",    32'(mem_addr),    32'(e_addr));
        chk("mem_wr_data", 32'(mem_wr_data), 32'(e_wd));
        chk("rsp_valid",   32'(rsp_valid),   32'((cyc == rsp_cyc) ? (4'b1 << t_id) : 4'b0));
        chk("rsp_data",    32'(rsp_data),    32'(e_rspd));
        for (int i = 0; i < 4; i++) begin
            if (((rsp_valid >> i) & 4'b1) != 4'b0) begin
                rsp_id_q.push_back(i);
                rsp_dat_q.push_back(rsp_data);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] r, input logic rw, input logic [2:0] a, input logic [7:0] d);
        logic [3:0] rdy;
        bit got;
        got = 1'b0;
        a_arr[r] = a; d_arr[r] = d; req_rd_wr[r] = rw; req_valid[r] = 1'b1;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk); rdy = req_ready;
            @(posedge clk); #1;
            if (rdy[r]) begin
                got = 1'b1;
                req_valid[r] = 1'b0;
            end
        end
        chk("send_accept", 32'(got), 32'd1);
    endtask

    task automatic drain(input int maxc);
        logic [3:0] rdy;
        int n;
        grant_q.delete();
        n = 0;
        while (req_valid != 4'b0 && n < maxc) begin
            @(negedge clk); rdy = req_ready;
            for (int i = 0; i < 4; i++)
                if (((rdy >> i) & 4'b1) != 4'b0) grant_q.push_back(i);
            @(posedge clk); #1;
            req_valid = req_valid & ~rdy;
            n++;
        end
        chk("drain_done", 32'(req_valid), 32'd0);
        repeat (RD_LAT + 4) @(posedge clk);
        #1;
    endtask

    task automatic new_cmd(input logic [1:0] r);
        req_rd_wr[r] = ($urandom_range(0, 9) < 4);
        a_arr[r]     = 3'($urandom_range(0, 7));
        d_arr[r]     = 8'($urandom_range(0, 255));
        req_valid[r] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] rdy;
        int k, guard;
        int en_q[$];
        bit got;

        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 3'd0;
            d_arr[i] = 8'd0;
        end
        for (int i = 0; i < 8; i++) begin
            env_mem[i] = 8'(i * 7 + 1);
            mmem[i]    = 8'(i * 7 + 1);
        end

        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_enable",    32'(mem_enable),  32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid),   32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // T1: write then read of address 3
        a_arr[0] = 3'd3; d_arr[0] = 8'hA5; req_rd_wr[0] = 1'b1; req_valid[0] = 1'b1;
        @(negedge clk); chk("t1_wr_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_wr_en",   32'(mem_enable),  32'd1);
        chk("t1_wr_rw",   32'(mem_rd_wr),   32'd1);
        chk("t1_wr_addr", 32'(mem_addr),    32'd3);
        chk("t1_wr_data", 32'(mem_wr_data), 32'hA5);
        @(posedge clk); #1;
        req_rd_wr[0] = 1'b0; req_valid[0] = 1'b1;
        @(negedge clk); chk("t1_rd_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_rd_en", 32'(mem_enable), 32'd1);
        chk("t1_rd_rw", 32'(mem_rd_wr),  32'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data",  32'(rsp_data),  32'hA5);
        @(posedge clk); #1;

        // T2: all four requesters read addresses 0..3
        for (int i = 0; i < 4; i++) send(2'd3, 1'b1, 3'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = 3'(i);
            req_rd_wr[i] = 1'b0;
        end
        rsp_id_q.delete(); rsp_dat_q.delete();
        req_valid = 4'hF;
        drain(100);
        chk("t2_ngrant", 32'(grant_q.size()), 32'd4);
        chk("t2_nrsp",   32'(rsp_id_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_q.size()) chk("t2_grant", 32'(grant_q[i]), 32'(i));
            if (i < rsp_id_q.size()) begin
                chk("t2_rsp_id",   32'(rsp_id_q[i]),  32'(i));
                chk("t2_rsp_data", 32'(rsp_dat_q[i]), 32'(8'h10 + i));
            end
        end

        // T3: after a grant to 1, requester 3 precedes requester 0
        send(2'd1, 1'b0, 3'd0, 8'd0);
        a_arr[0] = 3'd1; d_arr[0] = 8'h31; req_rd_wr[0] = 1'b1;
        a_arr[3] = 3'd2; d_arr[3] = 8'h32; req_rd_wr[3] = 1'b1;
        req_valid = 4'b1001;
        drain(100);
        chk("t3_ngrant", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            chk("t3_first",  32'(grant_q[0]), 32'd3);
            chk("t3_second", 32'(grant_q[1]), 32'd0);
        end

        // T4: back-to-back writes from requester 2
        k = 0; guard = 0;
        a_arr[2] = 3'd0; d_arr[2] = 8'h40; req_rd_wr[2] = 1'b1; req_valid[2] = 1'b1;
        en_q.delete();
        while (k < 8 && guard < 100) begin
            @(negedge clk); rdy = req_ready;
            if (mem_enable) en_q.push_back(cyc);
            if (!busy) chk("t4_idle_grants", 32'(req_ready), 32'h4);
            @(posedge clk); #1;
            guard++;
            if (rdy[2]) begin
                k++;
                if (k < 8) begin
                    a_arr[2] = 3'(k);
                    d_arr[2] = 8'(8'h40 + k);
                end else begin
                    req_valid[2] = 1'b0;
                end
            end
        end
        @(negedge clk); if (mem_enable) en_q.push_back(cyc);
        @(posedge clk); #1;
        chk("t4_count", 32'(en_q.size()), 32'd8);
        for (int j = 1; j < en_q.size(); j++)
            chk("t4_spacing", 32'(en_q[j] - en_q[j-1]), 32'd2);

        // T5: reset during the read wait
        a_arr[1] = 3'd5; req_rd_wr[1] = 1'b0; req_valid[1] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk); rdy = req_ready;
            @(posedge clk); #1;
            if (rdy[1]) got = 1'b1;
        end
        chk("t5_accept", 32'(got), 32'd1);
        req_valid[1] = 1'b0;
        a_arr[0] = 3'd6; d_arr[0] = 8'h66; req_rd_wr[0] = 1'b1;
        a_arr[2] = 3'd7; d_arr[2] = 8'h77; req_rd_wr[2] = 1'b1;
        req_valid = 4'b0101;
        @(posedge clk); #1;
        chk("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        model_reset();
        #1;
        chk("t5_ready",   32'(req_ready),   32'd0);
        chk("t5_rspv",    32'(rsp_valid),   32'd0);
        chk("t5_rspd",    32'(rsp_data),    32'd0);
        chk("t5_busy",    32'(busy),        32'd0);
        chk("t5_en",      32'(mem_enable),  32'd0);
        chk("t5_rw",      32'(mem_rd_wr),   32'd0);
        chk("t5_addr",    32'(mem_addr),    32'd0);
        chk("t5_wd",      32'(mem_wr_data), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        drain(50);
        chk("t5_ngrant", 32'(grant_q.size()), 32'd2);
        if (grant_q.size() == 2) begin
            chk("t5_first",  32'(grant_q[0]), 32'd0);
            chk("t5_second", 32'(grant_q[1]), 32'd2);
        end

        // Random traffic with re-requests and abandoned requests
        for (int c = 0; c < 600; c++) begin
            @(negedge clk); rdy = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[2'(i)] && rdy[2'(i)]) begin
                    req_valid[2'(i)] = 1'b0;
                    if ($urandom_range(0, 2) == 0) new_cmd(2'(i));
                end else if (req_valid[2'(i)]) begin
                    if ($urandom_range(0, 29) == 0) req_valid[2'(i)] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    new_cmd(2'(i));
                end
            end
        end
        req_valid = 4'b0;
        repeat (8) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
